// File: rtl/id_ex_pkg.sv
// Shared ID/EX definitions: forwarding select codes and width defaults.
// The select encoding is also used by the forwarding/hazard unit.
package id_ex_pkg;

    // Operand source selects driven by the forwarding unit
    localparam int IDSEL  = 0;
    localparam int EXSEL  = 1;
    localparam int MEMSEL = 2;
    localparam int WBSEL  = 3;

    // Width defaults
    localparam int DATA_W  = 16;
    localparam int RF_W    = 3;
    localparam int FSEL_W  = 2;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 16;

endpackage

// File: rtl/operand_fwd_mux.sv
// 4:1 operand forwarding mux: picks ID, EX, MEM or WB data.
// Ports: i_sel select, i_id/i_ex/i_mem/i_wb sources, o_data result.
module operand_fwd_mux
    import id_ex_pkg::*;
#(
    parameter int DataW = DATA_W,
    parameter int SelW  = FSEL_W
) (
    input  logic [SelW-1:0]  i_sel,
    input  logic [DataW-1:0] i_id,
    input  logic [DataW-1:0] i_ex,
    input  logic [DataW-1:0] i_mem,
    input  logic [DataW-1:0] i_wb,
    output logic [DataW-1:0] o_data
);

    always_comb begin
        o_data = i_id;
        case (i_sel)
            SelW'(IDSEL):  o_data = i_id;
            SelW'(EXSEL):  o_data = i_ex;
            SelW'(MEMSEL): o_data = i_mem;
            SelW'(WBSEL):  o_data = i_wb;
            default:       o_data = i_id;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and bubble insertion.
// Ports: clk/rst(sync, active-low), freeze/flush/stall controls,
//   selOp1/selOp2 + id/ex/mem/wb data in, id* decoded fields in,
//   ex* registered fields out, isLoadInEx, saturating bubbleCount.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int dataWidth         = DATA_W,
    parameter int rfWidth           = RF_W,
    parameter int opForwardSelWidth = FSEL_W,
    parameter int aluOpWidth        = ALUOP_W,
    parameter int cntWidth          = CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         flush,
    input  logic                         stall,
    input  logic [opForwardSelWidth-1:0] selOp1,
    input  logic [opForwardSelWidth-1:0] selOp2,
    input  logic [dataWidth-1:0]         idOp1Data,
    input  logic [dataWidth-1:0]         idOp2Data,
    input  logic [dataWidth-1:0]         exFwdData,
    input  logic [dataWidth-1:0]         memFwdData,
    input  logic [dataWidth-1:0]         wbFwdData,
    input  logic [dataWidth-1:0]         idImm,
    input  logic                         idUseImm,
    input  logic                         idWriteEn,
    input  logic                         idIsLoad,
    input  logic                         idMemWrite,
    input  logic                         idValid,
    input  logic [rfWidth-1:0]           idRfWriteAddr,
    input  logic [aluOpWidth-1:0]        idAluOp,
    output logic [dataWidth-1:0]         exOp1,
    output logic [dataWidth-1:0]         exOp2,
    output logic [dataWidth-1:0]         exImm,
    output logic                         exUseImm,
    output logic                         exWriteEn,
    output logic                         exIsLoad,
    output logic                         exMemWrite,
    output logic                         exValid,
    output logic [rfWidth-1:0]           exRfWriteAddr,
    output logic [aluOpWidth-1:0]        exAluOp,
    output logic                         isLoadInEx,
    output logic [cntWidth-1:0]          bubbleCount
);

    logic [dataWidth-1:0]  w_fwdOp1;
    logic [dataWidth-1:0]  w_fwdOp2;
    logic                  w_bubble;
    logic                  w_count;

    logic [dataWidth-1:0]  r_op1;
    logic [dataWidth-1:0]  r_op2;
    logic [dataWidth-1:0]  r_imm;
    logic                  r_useImm;
    logic                  r_writeEn;
    logic                  r_isLoad;
    logic                  r_memWrite;
    logic                  r_valid;
    logic [rfWidth-1:0]    r_rfWriteAddr;
    logic [aluOpWidth-1:0] r_aluOp;
    logic [cntWidth-1:0]   r_bubbleCount;

    operand_fwd_mux #(
        .DataW (dataWidth),
        .SelW  (opForwardSelWidth)
    ) u_mux_op1 (
        .i_sel  (selOp1),
        .i_id   (idOp1Data),
        .i_ex   (exFwdData),
        .i_mem  (memFwdData),
        .i_wb   (wbFwdData),
        .o_data (w_fwdOp1)
    );

    operand_fwd_mux #(
        .DataW (dataWidth),
        .SelW  (opForwardSelWidth)
    ) u_mux_op2 (
        .i_sel  (selOp2),
        .i_id   (idOp2Data),
        .i_ex   (exFwdData),
        .i_mem  (memFwdData),
        .i_wb   (wbFwdData),
        .o_data (w_fwdOp2)
    );

    // Flush outranks stall, so a simultaneous flush takes no count
    assign w_bubble = flush | stall;
    assign w_count  = ~flush & stall & (r_bubbleCount != '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op1         <= '0;
            r_op2         <= '0;
            r_imm         <= '0;
            r_useImm      <= 1'b0;
            r_writeEn     <= 1'b0;
            r_isLoad      <= 1'b0;
            r_memWrite    <= 1'b0;
            r_valid       <= 1'b0;
            r_rfWriteAddr <= '0;
            r_aluOp       <= '0;
            r_bubbleCount <= '0;
        end else if (!freeze) begin
            if (w_bubble) begin
                r_op1         <= '0;
                r_op2         <= '0;
                r_imm         <= '0;
                r_useImm      <= 1'b0;
                r_writeEn     <= 1'b0;
                r_isLoad      <= 1'b0;
                r_memWrite    <= 1'b0;
                r_valid       <= 1'b0;
                r_rfWriteAddr <= '0;
                r_aluOp       <= '0;
            end else begin
                r_op1         <= w_fwdOp1;
                r_op2         <= w_fwdOp2;
                r_imm         <= idImm;
                r_useImm      <= idUseImm;
                // Side-effecting controls only survive for valid instructions
                r_writeEn     <= idWriteEn & idValid;
                r_isLoad      <= idIsLoad & idValid;
                r_memWrite    <= idMemWrite & idValid;
                r_valid       <= idValid;
                r_rfWriteAddr <= idRfWriteAddr;
                r_aluOp       <= idAluOp;
            end
            if (w_count) begin
                r_bubbleCount <= r_bubbleCount + 1'b1;
            end
        end
    end

    assign exOp1         = r_op1;
    assign exOp2         = r_op2;
    assign exImm         = r_imm;
    assign exUseImm      = r_useImm;
    assign exWriteEn     = r_writeEn;
    assign exIsLoad      = r_isLoad;
    assign exMemWrite    = r_memWrite;
    assign exValid       = r_valid;
    assign exRfWriteAddr = r_rfWriteAddr;
    assign exAluOp       = r_aluOp;
    assign bubbleCount   = r_bubbleCount;

    // Registered-only path so the hazard unit sees no loop through us
    assign isLoadInEx    = r_isLoad & r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// A second instance with a 4-bit counter exercises saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        stall;
    logic [1:0]  selOp1;
    logic [1:0]  selOp2;
    logic [15:0] idOp1Data;
    logic [15:0] idOp2Data;
    logic [15:0] exFwdData;
    logic [15:0] memFwdData;
    logic [15:0] wbFwdData;
    logic [15:0] idImm;
    logic        idUseImm;
    logic        idWriteEn;
    logic        idIsLoad;
    logic        idMemWrite;
    logic        idValid;
    logic [2:0]  idRfWriteAddr;
    logic [2:0]  idAluOp;

    logic [15:0] exOp1, exOp2, exImm;
    logic        exUseImm, exWriteEn, exIsLoad, exMemWrite, exValid;
    logic [2:0]  exRfWriteAddr, exAluOp;
    logic        isLoadInEx;
    logic [15:0] bubbleCount;

    logic [15:0] sOp1, sOp2, sImm;
    logic        sUseImm, sWriteEn, sIsLoad, sMemWrite, sValid;
    logic [2:0]  sRfWriteAddr, sAluOp;
    logic        sIsLoadInEx;
    logic [3:0]  sBubbleCount;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    id_ex_stage u_dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .stall(stall), .selOp1(selOp1), .selOp2(selOp2),
        .idOp1Data(idOp1Data), .idOp2Data(idOp2Data),
        .exFwdData(exFwdData), .memFwdData(memFwdData),
        .wbFwdData(wbFwdData), .idImm(idImm),
        .idUseImm(idUseImm), .idWriteEn(idWriteEn),
        .idIsLoad(idIsLoad), .idMemWrite(idMemWrite),
        .idValid(idValid), .idRfWriteAddr(idRfWriteAddr),
        .idAluOp(idAluOp),
        .exOp1(exOp1), .exOp2(exOp2), .exImm(exImm),
        .exUseImm(exUseImm), .exWriteEn(exWriteEn),
        .exIsLoad(exIsLoad), .exMemWrite(exMemWrite),
        .exValid(exValid), .exRfWriteAddr(exRfWriteAddr),
        .exAluOp(exAluOp), .isLoadInEx(isLoadInEx),
        .bubbleCount(bubbleCount)
    );

    id_ex_stage #(.cntWidth(4)) u_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .stall(stall), .selOp1(selOp1), .selOp2(selOp2),
        .idOp1Data(idOp1Data), .idOp2Data(idOp2Data),
        .exFwdData(exFwdData), .memFwdData(memFwdData),
        .wbFwdData(wbFwdData), .idImm(idImm),
        .idUseImm(idUseImm), .idWriteEn(idWriteEn),
        .idIsLoad(idIsLoad), .idMemWrite(idMemWrite),
        .idValid(idValid), .idRfWriteAddr(idRfWriteAddr),
        .idAluOp(idAluOp),
        .exOp1(sOp1), .exOp2(sOp2), .exImm(sImm),
        .exUseImm(sUseImm), .exWriteEn(sWriteEn),
        .exIsLoad(sIsLoad), .exMemWrite(sMemWrite),
        .exValid(sValid), .exRfWriteAddr(sRfWriteAddr),
        .exAluOp(sAluOp), .isLoadInEx(sIsLoadInEx),
        .bubbleCount(sBubbleCount)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are read there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] srcTab [4];

    initial begin
        srcTab[0] = 16'h1111;
        srcTab[1] = 16'h2222;
        srcTab[2] = 16'h3333;
        srcTab[3] = 16'h4444;

        // Reset with random inputs
        rst = 1'b0;
        freeze = 1'b0;
        flush = $urandom_range(0, 1) == 1;
        stall = $urandom_range(0, 1) == 1;
        selOp1 = 2'($urandom);
        selOp2 = 2'($urandom);
        idOp1Data = 16'($urandom);
        idOp2Data = 16'($urandom);
        exFwdData = 16'($urandom);
        memFwdData = 16'($urandom);
        wbFwdData = 16'($urandom);
        idImm = 16'($urandom);
        idUseImm = 1'b1;
        idWriteEn = 1'b1;
        idIsLoad = 1'b1;
        idMemWrite = 1'b1;
        idValid = 1'b1;
        idRfWriteAddr = 3'($urandom);
        idAluOp = 3'($urandom);
        step();
        step();
        chk("rst_op1", 32'(exOp1), 32'h0);
        chk("rst_op2", 32'(exOp2), 32'h0);
        chk("rst_imm", 32'(exImm), 32'h0);
        chk("rst_ctl", 32'({exUseImm, exWriteEn, exIsLoad,
                            exMemWrite, exValid, isLoadInEx}), 32'h0);
        chk("rst_rd_alu", 32'({exRfWriteAddr, exAluOp}), 32'h0);
        chk("rst_cnt", 32'(bubbleCount), 32'h0);
        chk("rst_cnt_sat", 32'(sBubbleCount), 32'h0);

        // Forwarding
        rst = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        idOp1Data = 16'h1111;
        idOp2Data = 16'h1111;
        exFwdData = 16'h2222;
        memFwdData = 16'h3333;
        wbFwdData = 16'h4444;
        idImm = 16'h00a5;
        idUseImm = 1'b0;
        idWriteEn = 1'b1;
        idIsLoad = 1'b0;
        idMemWrite = 1'b0;
        idValid = 1'b1;
        idRfWriteAddr = 3'd1;
        idAluOp = 3'd2;
        selOp1 = 2'd1;
        selOp2 = 2'd3;
        step();
        chk("fwd_op1_ex", 32'(exOp1), 32'h2222);
        chk("fwd_op2_wb", 32'(exOp2), 32'h4444);
        chk("fwd_imm", 32'(exImm), 32'h00a5);
        chk("fwd_valid", 32'(exValid), 32'h1);
        chk("fwd_wen", 32'(exWriteEn), 32'h1);
        for (int i = 0; i < 16; i++) begin
            selOp1 = 2'(i / 4);
            selOp2 = 2'(i % 4);
            step();
            chk($sformatf("sweep_op1_%0d", i), 32'(exOp1),
                32'(srcTab[i / 4]));
            chk($sformatf("sweep_op2_%0d", i), 32'(exOp2),
                32'(srcTab[i % 4]));
        end

        // Load r2 into EX
        selOp1 = 2'd0;
        selOp2 = 2'd0;
        idIsLoad = 1'b1;
        idRfWriteAddr = 3'd2;
        idAluOp = 3'd0;
        step();
        chk("ld_isLoadInEx", 32'(isLoadInEx), 32'h1);
        chk("ld_rd", 32'(exRfWriteAddr), 32'h2);

        // Dependent instruction stalls one cycle
        idIsLoad = 1'b0;
        idRfWriteAddr = 3'd3;
        idAluOp = 3'd5;
        stall = 1'b1;
        step();
        chk("stall_valid", 32'(exValid), 32'h0);
        chk("stall_wen", 32'(exWriteEn), 32'h0);
        chk("stall_op1", 32'(exOp1), 32'h0);
        chk("stall_isLoadInEx", 32'(isLoadInEx), 32'h0);
        chk("stall_cnt", 32'(bubbleCount), 32'h1);

        // Held instruction loads with MEM forwarding
        stall = 1'b0;
        selOp1 = 2'd2;
        step();
        chk("resume_valid", 32'(exValid), 32'h1);
        chk("resume_op1", 32'(exOp1), 32'h3333);
        chk("resume_rd", 32'(exRfWriteAddr), 32'h3);
        chk("resume_alu", 32'(exAluOp), 32'h5);
        chk("resume_cnt", 32'(bubbleCount), 32'h1);

        // Freeze beats flush and stall
        freeze = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        selOp1 = 2'd3;
        idRfWriteAddr = 3'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_op1", 32'(exOp1), 32'h3333);
            chk("frz_valid", 32'(exValid), 32'h1);
            chk("frz_rd", 32'(exRfWriteAddr), 32'h3);
            chk("frz_cnt", 32'(bubbleCount), 32'h1);
        end

        // Flush beats stall, no count
        freeze = 1'b0;
        step();
        chk("fls_valid", 32'(exValid), 32'h0);
        chk("fls_op1", 32'(exOp1), 32'h0);
        chk("fls_rd", 32'(exRfWriteAddr), 32'h0);
        chk("fls_cnt", 32'(bubbleCount), 32'h1);

        // Invalid instruction: controls dropped, data kept
        flush = 1'b0;
        stall = 1'b0;
        selOp1 = 2'd0;
        idValid = 1'b0;
        idWriteEn = 1'b1;
        idIsLoad = 1'b1;
        idMemWrite = 1'b1;
        idRfWriteAddr = 3'd4;
        step();
        chk("inv_wen", 32'(exWriteEn), 32'h0);
        chk("inv_ld", 32'(exIsLoad), 32'h0);
        chk("inv_mw", 32'(exMemWrite), 32'h0);
        chk("inv_valid", 32'(exValid), 32'h0);
        chk("inv_op1", 32'(exOp1), 32'h1111);
        chk("inv_rd", 32'(exRfWriteAddr), 32'h4);

        // Saturation: both counters start at 1
        idValid = 1'b1;
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("sat_reach", 32'(sBubbleCount), 32'hf);
        end
        chk("sat_hold", 32'(sBubbleCount), 32'hf);
        chk("cnt16_21", 32'(bubbleCount), 32'd21);

        // Reset mid-stall
        rst = 1'b0;
        step();
        chk("rmid_cnt", 32'(bubbleCount), 32'h0);
        chk("rmid_valid", 32'(exValid), 32'h0);
        chk("rmid_op1", 32'(exOp1), 32'h0);
        rst = 1'b1;
        stall = 1'b0;
        step();
        chk("rpost_valid", 32'(exValid), 32'h1);
        chk("rpost_op1", 32'(exOp1), 32'h1111);
        chk("rpost_ld", 32'(isLoadInEx), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated operand forwarding muxes and bubble insertion. Sits directly downstream of the forwarding/hazard unit. It consumes that unit's `stall`, `selOp1` and `selOp2` to pick each operand from ID, EX, MEM or WB, then registers the decoded instruction into the EX stage. It also feeds the EX-stage destination, write-enable and load flag back to the forwarding unit, and keeps a saturating count of load-use bubbles.

## Interface
- `dataWidth`, 16, register/operand width
- `rfWidth`, 3, register-file address width
- `opForwardSelWidth`, 2, forwarding select width
- `aluOpWidth`, 3, ALU opcode width
- `cntWidth`, 16, bubble counter width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous active-low reset; all registers are cleared when `rst`=0 at the rising edge of `clk`
- `freeze`  in  1  global hold (memory wait); holds all registers
- `flush`  in  1  squash the instruction in ID (taken branch/jump)
- `stall`  in  1  load-use stall from the forwarding unit
- `selOp1`, `selOp2`  in  opForwardSelWidth  operand source selects: 0=ID, 1=EX, 2=MEM, 3=WB
- `idOp1Data`, `idOp2Data`  in  dataWidth  register-file read data
- `exFwdData`, `memFwdData`, `wbFwdData`  in  dataWidth  forwarding results
- `idImm`  in  dataWidth  sign-extended immediate
- `idUseImm`, `idWriteEn`, `idIsLoad`, `idMemWrite`, `idValid`  in  1  decoded controls
- `idRfWriteAddr`  in  rfWidth  destination register
- `idAluOp`  in  aluOpWidth  ALU operation
- `exOp1`, `exOp2`, `exImm`  out  dataWidth  registered operands/immediate
- `exUseImm`, `exWriteEn`, `exIsLoad`, `exMemWrite`, `exValid`  out  1  registered controls
- `exRfWriteAddr`  out  rfWidth  registered destination
- `exAluOp`  out  aluOpWidth  registered ALU op
- `isLoadInEx`  out  1  `exIsLoad & exValid`, returned to the forwarding unit
- `bubbleCount`  out  cntWidth  saturating count of stall-inserted bubbles

## Operation
- Forwarding mux, per operand (combinational): `fwdOpN` = sel 0 → `idOpNData`, sel 1 → `exFwdData`, sel 2 → `memFwdData`, sel 3 → `wbFwdData`.
- Each clock edge applies exactly one action, in strict priority order:
  1. `rst`=0 → clear. All outputs become 0, including `bubbleCount`.
  2. `freeze`=1 → hold every register, including `bubbleCount`.
  3. `flush`=1 → load a bubble. `bubbleCount` is unchanged.
  4. `stall`=1 → load a bubble and increment `bubbleCount`.
  5. Otherwise → load `fwdOp1`, `fwdOp2` and all `id*` fields. `exValid` takes `idValid`.
- Bubble: `exValid`, `exWriteEn`, `exIsLoad` and `exMemWrite` are all 0. `exOp1`, `exOp2`, `exImm`, `exRfWriteAddr`, `exAluOp` and `exUseImm` are also 0.
- Load with `idValid`=0: control bits `exWriteEn`, `exIsLoad` and `exMemWrite` are forced to 0. The data fields still load.
- `bubbleCount` saturates at all-ones and does not wrap.
- `flush` and `stall` asserted together: flush wins, and no count is taken.

## Timing
- Latency: 1 cycle from the ID inputs and selects to the `ex*` outputs.
- Forwarding selects and data are sampled in the same cycle as the edge they are captured on.
- No combinational path from any input to any output.
- `isLoadInEx` is derived from registered state only. This breaks the stall loop with the forwarding unit.
- A load-use stall lasts exactly one cycle. The bubble enters EX on that edge, so `isLoadInEx`=0 next cycle, `stall` drops, and the held ID instruction then loads with MEM forwarding.
- Reset mid-stall or mid-freeze: outputs are 0 on the next cycle, and normal loading resumes the cycle after `rst` returns to 1.

## Structure
- Shared package/include: `IDSEL`=0, `EXSEL`=1, `MEMSEL`=2, `WBSEL`=3, plus the width defaults. These are shared with the forwarding unit.
- One sub-module, `operand_fwd_mux`: parameterised 4:1 data mux, instantiated twice.
- Top level: priority next-state logic, the pipeline register bank and the saturating counter.

## Test plan
- Reset: `rst`=0 for 2 cycles with random inputs → every output is 0, `bubbleCount`=0.
- Forwarding: `idOp1Data`=0x1111, `exFwdData`=0x2222, `memFwdData`=0x3333, `wbFwdData`=0x4444.
  - sel1=1, sel2=3 → `exOp1`=0x2222, `exOp2`=0x4444 next cycle.
  - Sweep all 16 sel combinations.
- Load-use: load r2 into EX, then `stall`=1 for one cycle.
  - That cycle yields a bubble: `exValid`=0, `exWriteEn`=0, `bubbleCount`=1.
  - The next load carries the ID instruction with `exValid`=1.
- Freeze priority: `freeze`=1 with `flush`=1 and `stall`=1 for 3 cycles → outputs and `bubbleCount` unchanged.
- Flush and stall together: `flush`=1, `stall`=1 → bubble with `bubbleCount` unchanged.
- Saturation: `cntWidth`=4 with 20 stall cycles → `bubbleCount` holds at 15. Also check that `idValid`=0 gives `exWriteEn`=0 even when `idWriteEn`=1.
